// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU-op and decoder control definitions for the MIPS pipeline
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [2:0] ALU_R    = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b111;
  localparam logic [2:0] ALU_BR   = 3'b010;
  localparam logic [1:0] BR_NONE  = 2'd0;
  localparam logic [1:0] BR_BEQ   = 2'd1;
  localparam logic [1:0] BR_BNE   = 2'd2;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       reg_dst;
    logic       sign_extend;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic [1:0] branch;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the instruction in ID
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hazard
);
  logic uses_rt;
  assign uses_rt = ~id_alu_src | id_mem_write;
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and a saturating stall counter
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              id_reg_write_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_sign_extend_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic [2:0]        id_alu_op_i,
  input  logic [1:0]        id_branch_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_dst_o,
  output logic              ex_sign_extend_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic [2:0]        ex_alu_op_o,
  output logic [1:0]        ex_branch_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  ctrl_t id_ctrl, ex_ctrl;
  logic hazard, bubble;
  assign id_ctrl = '{id_reg_write_i, id_alu_src_i, id_reg_dst_i, id_sign_extend_i,
                     id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_alu_op_i, id_branch_i};
  assign {ex_reg_write_o, ex_alu_src_o, ex_reg_dst_o, ex_sign_extend_o, ex_mem_read_o,
          ex_mem_write_o, ex_mem_to_reg_o, ex_alu_op_o, ex_branch_o} = ex_ctrl;
  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid     (id_valid_i),
    .id_alu_src   (id_alu_src_i),
    .id_mem_write (id_mem_write_i),
    .id_rs        (id_rs_i),
    .id_rt        (id_rt_i),
    .ex_valid     (ex_valid_o),
    .ex_mem_read  (ex_ctrl.mem_read),
    .ex_rt        (ex_rt_o),
    .hazard       (hazard)
  );
  assign stall_o = hazard & ~flush_i;
  assign bubble = flush_i | stall_o;
  // Load the stage, or squash controls into a bubble on flush/stall; operands always capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl      <= CTRL_NOP;
      ex_valid_o   <= 1'b0;
      ex_pc4_o     <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      stall_cnt_o  <= '0;
    end else begin
      ex_ctrl      <= bubble ? CTRL_NOP : id_ctrl;
      ex_valid_o   <= id_valid_i & ~bubble;
      ex_pc4_o     <= id_pc4_i;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      stall_cnt_o  <= (stall_o & ~&stall_cnt_o) ? stall_cnt_o + CNT_W'(1) : stall_cnt_o;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage with directed load-use, flush and saturation vectors
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst, id_valid, flush, stall;
  ctrl_t idc, exc;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic ex_valid;
  logic [3:0] cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic        stall;
    logic        valid;
    ctrl_t       ctrl;
    logic        chk;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, pc4, rsd, rtd;
    logic [3:0]  cnt;
  } exp_t;
  exp_t q[$];
  localparam ctrl_t C_ADDI = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, BR_NONE};
  localparam ctrl_t C_LW   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD, BR_NONE};
  localparam ctrl_t C_SW   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, BR_NONE};
  localparam ctrl_t C_R    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_R, BR_NONE};
  localparam ctrl_t C_BEQ  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_BR, BR_BEQ};

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_reg_write_i(idc.reg_write), .id_alu_src_i(idc.alu_src), .id_reg_dst_i(idc.reg_dst),
    .id_sign_extend_i(idc.sign_extend), .id_mem_read_i(idc.mem_read), .id_mem_write_i(idc.mem_write),
    .id_mem_to_reg_i(idc.mem_to_reg), .id_alu_op_i(idc.alu_op), .id_branch_i(idc.branch),
    .id_pc4_i(id_pc4), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .flush_i(flush), .stall_o(stall),
    .ex_valid_o(ex_valid),
    .ex_reg_write_o(exc.reg_write), .ex_alu_src_o(exc.alu_src), .ex_reg_dst_o(exc.reg_dst),
    .ex_sign_extend_o(exc.sign_extend), .ex_mem_read_o(exc.mem_read), .ex_mem_write_o(exc.mem_write),
    .ex_mem_to_reg_o(exc.mem_to_reg), .ex_alu_op_o(exc.alu_op), .ex_branch_o(exc.branch),
    .ex_pc4_o(ex_pc4), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .stall_cnt_o(cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic f, input ctrl_t c,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] imm, input logic es, input int ecnt);
    exp_t e;
    logic b;
    @(negedge clk);
    rst = r; id_valid = v; flush = f; idc = c;
    id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
    id_pc4 = imm + 32'h400; id_rs_data = imm ^ 32'h5a5a_0000; id_rt_data = ~imm;
    b = f | es;
    e.stall = es;
    e.valid = ~r & v & ~b;
    e.ctrl = (r | b) ? CTRL_NOP : c;
    e.chk = r | e.valid;
    e.rs = r ? 5'd0 : rs; e.rt = r ? 5'd0 : rt; e.rd = r ? 5'd0 : rd;
    e.imm = r ? 32'd0 : imm; e.pc4 = r ? 32'd0 : id_pc4;
    e.rsd = r ? 32'd0 : id_rs_data; e.rtd = r ? 32'd0 : id_rt_data;
    e.cnt = 4'(ecnt);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_o", 32'(stall), 32'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_ctrl", 32'(exc), 32'(e.ctrl));
        chk("stall_cnt", 32'(cnt), 32'(e.cnt));
        if (e.chk) begin
          chk("ex_rs", 32'(ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(ex_rt), 32'(e.rt));
          chk("ex_rd", 32'(ex_rd), 32'(e.rd));
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_pc4", ex_pc4, e.pc4);
          chk("ex_rs_data", ex_rs_data, e.rsd);
          chk("ex_rt_data", ex_rt_data, e.rtd);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; idc = CTRL_NOP;
    id_rs = '0; id_rt = '0; id_rd = '0; id_imm = '0; id_pc4 = '0; id_rs_data = '0; id_rt_data = '0;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), ctrl_t'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom, 0, 0);
    step(0, 1, 0, C_ADDI, 1, 2, 0, 32'd5, 0, 0);
    step(0, 1, 0, C_LW, 1, 8, 0, 32'd16, 0, 0);
    step(0, 1, 0, C_R, 8, 9, 10, 32'h0000_5020, 1, 1);
    step(0, 1, 0, C_R, 8, 9, 10, 32'h0000_5020, 0, 1);
    step(0, 1, 0, C_LW, 1, 8, 0, 32'd20, 0, 1);
    step(0, 1, 0, C_ADDI, 3, 8, 0, 32'd7, 0, 1);
    step(0, 1, 0, C_LW, 1, 0, 0, 32'd24, 0, 1);
    step(0, 1, 0, C_R, 0, 0, 4, 32'h0000_2020, 0, 1);
    step(0, 1, 0, C_ADDI, 1, 8, 0, 32'd9, 0, 1);
    step(0, 1, 0, C_R, 8, 1, 3, 32'h0000_1820, 0, 1);
    step(0, 1, 0, C_LW, 1, 7, 0, 32'd28, 0, 1);
    step(0, 1, 0, C_SW, 2, 7, 0, 32'd32, 1, 2);
    step(0, 1, 0, C_SW, 2, 7, 0, 32'd32, 0, 2);
    step(0, 1, 0, C_LW, 1, 5, 0, 32'd36, 0, 2);
    step(0, 1, 0, C_BEQ, 6, 5, 0, 32'hffff_fffc, 1, 3);
    step(0, 1, 0, C_BEQ, 6, 5, 0, 32'hffff_fffc, 0, 3);
    step(0, 1, 0, C_LW, 1, 8, 0, 32'd40, 0, 3);
    step(0, 1, 1, C_R, 8, 9, 10, 32'h0000_5020, 0, 3);
    step(0, 1, 0, C_ADDI, 4, 11, 0, 32'd1, 0, 3);
    step(0, 1, 0, C_LW, 1, 8, 0, 32'd44, 0, 3);
    step(0, 0, 0, C_R, 8, 9, 10, 32'h0000_5020, 0, 3);
    step(0, 1, 0, C_LW, 1, 8, 0, 32'd48, 0, 3);
    step(1, 1, 0, C_R, 8, 9, 10, 32'h0000_5020, 1, 0);
    step(0, 1, 0, C_R, 8, 9, 10, 32'h0000_5020, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, C_LW, 1, 8, 0, 32'(i), 0, (i - 1 > 15) ? 15 : i - 1);
      step(0, 1, 0, C_R, 8, 2, 3, 32'(i + 100), 1, (i > 15) ? 15 : i);
    end
    step(0, 1, 0, C_R, 8, 2, 3, 32'd200, 0, 15);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS CPU, between the instruction decoder and the execute stage. It registers the decoder's control bundle and the ID-stage operands into the EX stage. It detects load-use hazards, requests a one-cycle front-end freeze, and inserts bubbles on stall or on a branch flush. A saturating counter records stall cycles for performance checks.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  IF/ID holds a real instruction
- id_reg_write_i, id_alu_src_i, id_reg_dst_i, id_sign_extend_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  in  1 each  decoder controls
- id_alu_op_i  in  3  decoder ALU op
- id_branch_i  in  2  0 none, 1 BEQ, 2 BNE
- id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i  in  DATA_W each  ID operands
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW each  register addresses
- flush_i  in  1  taken-branch redirect from a later stage
- stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_valid_o  out  1  EX holds a real instruction
- ex_* outputs  out  same widths as the id_* inputs  registered copies of every id_* control, operand and address
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Reset: clk_i and rst_i are the only clock and reset. The reset is synchronous, active-high, and decided as fixed. With rst_i=1 at a rising edge, every ex_* output, ex_valid_o and stall_cnt_o become 0.
- id_uses_rt = (id_alu_src_i==0) | id_mem_write_i. This covers R-format, BEQ, BNE and SW. For ADDI, ORI, LUI and LW, rt is a destination only.
- hazard = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rt_o!=0) & ((ex_rt_o==id_rs_i) | (id_uses_rt & ex_rt_o==id_rt_i)).
- stall_o = hazard & ~flush_i.
- Per-edge priority:
  1. rst_i: clear everything.
  2. flush_i: insert a bubble.
  3. stall_o: insert a bubble.
  4. Otherwise load: every ex_* takes its id_* value and ex_valid_o takes id_valid_i.
- Bubble:
  - ex_valid_o and every control output are cleared: reg_write, alu_src, reg_dst, sign_extend, mem_read, mem_write, mem_to_reg, alu_op=000, branch=00.
  - Data and address outputs still capture their inputs. Their values are don't-care while ex_valid_o=0.
- A bubble must never write a register or memory, and must never branch.
- stall_cnt_o increments by 1 on each edge with stall_o=1 and rst_i=0. It holds at 2^CNT_W-1 once reached. A flush does not count.
- There is no FSM. State is the ID/EX register plus the counter.

## Timing
- Latency: ID inputs appear on ex_* one rising edge later.
- stall_o is a same-cycle combinational function of id_* and registered ex_* values. It has no path from the ex_* inputs of the next cycle.
- A stall lasts exactly one cycle. The bubble clears ex_valid_o, so the hazard drops the next cycle. The held instruction then loads on the following edge.
- flush_i together with hazard: flush wins, stall_o=0, the counter does not increment, and the PC redirect proceeds.
- The $0 destination never stalls.
- Reset asserted during a stall cycle clears the stage. stall_o then falls in the next cycle because ex_valid_o=0.
- Reset has no effect on stall_o within its own cycle other than through the registered state.

## Structure
- The shared package cpu_pkg holds:
  - the opcode constants 0, 4, 5, 8, 13, 15, 35, 43
  - the ALU-op encodings: R-format 100, ADDI/LW/SW 000, ORI 101, LUI 111, branch 010
  - a packed ctrl_t struct of all decoder control fields
  - the bubble constant CTRL_NOP (all zero)
- One sub-module, hazard_detect, is the purely combinational load-use compare that produces hazard.
- The top module holds the registers, the priority logic and the counter.

## Test plan
- Reset: rst_i=1 for 2 cycles with random inputs -> all ex_*, ex_valid_o and stall_cnt_o equal 0, and stall_o=0.
- ADDI pass-through: id_valid=1, reg_write=1, alu_src=1, alu_op=000, rs=1, rt=2, imm=5 -> next edge ex_alu_op=000, ex_rt=2, ex_imm=5, ex_valid=1; stall_o=0 throughout.
- Load-use: EX holds LW with rt=8; ID R-format with rs=8 -> stall_o=1 that cycle, then ex_valid=0 with controls 0 and stall_cnt=1. Next cycle stall_o=0, and the R-format is in EX one edge later.
- No false hazard:
  - EX LW rt=8, ID ADDI rt=8 rs=3 -> stall_o=0.
  - EX LW rt=0, ID rs=0 -> stall_o=0.
  - EX ADDI rt=8, ID rs=8 -> stall_o=0.
- Flush with hazard: the load-use setup plus flush_i=1 -> stall_o=0, next edge bubble, stall_cnt unchanged.
- Saturation: CNT_W=4 with 20 separate load-use events -> stall_cnt_o reads 15 and stays 15.
